// File: rtl/acl_frame_fwd_ctrl.sv
// Frame sequencer between the ingress FIFO and egress AXI-Stream: buffers the Eth+IPv4 header,
// asks the ACL for a verdict, then either replays header + cut-through body or discards the frame.
module acl_frame_fwd_ctrl #(
    parameter int          HDR_WORDS      = 9,
    parameter logic [15:0] ETYPE_IPV4     = 16'h0800,
    parameter int          LKP_TIMEOUT    = 64,
    parameter bit          DEFAULT_PERMIT = 1'b0,
    parameter int          CNT_W          = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_fifo_empty,
    input  logic [31:0]      i_fifo_tdata,
    input  logic             i_fifo_tlast,
    output logic             o_fifo_rd_en,
    output logic             o_lkp_req,
    output logic [31:0]      o_lkp_src_ip,
    output logic [31:0]      o_lkp_dst_ip,
    output logic [7:0]       o_lkp_proto,
    input  logic             i_lkp_ack,
    input  logic             i_lkp_permit,
    output logic [31:0]      o_txd_tdata,
    output logic             o_txd_tvalid,
    output logic             o_txd_tlast,
    input  logic             i_txd_tready,
    output logic [CNT_W-1:0] o_fwd_cnt,
    output logic [CNT_W-1:0] o_drop_cnt,
    output logic [CNT_W-1:0] o_timeout_cnt
);

    localparam int         TMR_W    = $clog2(LKP_TIMEOUT + 1);
    localparam logic [3:0] LAST_IDX = 4'(HDR_WORDS - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_HDR, S_LOOKUP, S_FWD_HDR, S_FWD_BODY, S_DROP
    } state_t;

    state_t             state_q;
    logic [3:0]         idx_q;
    logic [TMR_W-1:0]   timer_q;
    logic               hdr_last_q;
    logic [31:0]        hbuf_q [HDR_WORDS];
    logic               lkp_req_q;
    logic [31:0]        src_ip_q;
    logic [31:0]        dst_ip_q;
    logic [7:0]         proto_q;
    logic [CNT_W-1:0]   fwd_cnt_q;
    logic [CNT_W-1:0]   drop_cnt_q;
    logic [CNT_W-1:0]   timeout_cnt_q;

    logic               rd_en_d;
    logic               tvalid_d;
    logic [31:0]        tdata_d;
    logic               tlast_d;
    logic               hdr_done;
    logic               runt;
    logic               is_ipv4;
    logic               lkp_ack;
    logic               lkp_timeout;
    logic               decide;
    logic               permit;
    logic               frame_last;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    // Egress and FIFO pop are combinational so the body can cut through without a bubble.
    always_comb begin
        rd_en_d  = 1'b0;
        tvalid_d = 1'b0;
        tdata_d  = '0;
        tlast_d  = 1'b0;
        case (state_q)
            S_HDR, S_DROP: rd_en_d = !i_fifo_empty;
            S_FWD_HDR: begin
                tvalid_d = 1'b1;
                tdata_d  = hbuf_q[idx_q];
                tlast_d  = (idx_q == LAST_IDX) && hdr_last_q;
            end
            S_FWD_BODY: begin
                tvalid_d = !i_fifo_empty;
                tdata_d  = i_fifo_tdata;
                tlast_d  = i_fifo_tlast;
                rd_en_d  = !i_fifo_empty && i_txd_tready;
            end
            default: ;
        endcase
    end

    assign hdr_done    = (state_q == S_HDR) && rd_en_d && (idx_q == LAST_IDX);
    assign runt        = (state_q == S_HDR) && rd_en_d && i_fifo_tlast && (idx_q != LAST_IDX);
    assign is_ipv4     = (hbuf_q[3][31:16] == ETYPE_IPV4);
    assign lkp_ack     = (state_q == S_LOOKUP) && i_lkp_ack;
    assign lkp_timeout = (state_q == S_LOOKUP) && !i_lkp_ack && (timer_q == TMR_W'(LKP_TIMEOUT - 1));
    // Non-IPv4 headers skip the lookup and share the decision path with ack/timeout.
    assign decide      = (hdr_done && !is_ipv4) || lkp_ack || lkp_timeout;
    assign permit      = lkp_ack ? i_lkp_permit : DEFAULT_PERMIT;
    assign frame_last  = hdr_done ? i_fifo_tlast : hdr_last_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            idx_q         <= '0;
            timer_q       <= '0;
            hdr_last_q    <= 1'b0;
            lkp_req_q     <= 1'b0;
            src_ip_q      <= '0;
            dst_ip_q      <= '0;
            proto_q       <= '0;
            fwd_cnt_q     <= '0;
            drop_cnt_q    <= '0;
            timeout_cnt_q <= '0;
            for (int i = 0; i < HDR_WORDS; i++) hbuf_q[i] <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    idx_q <= '0;
                    if (!i_fifo_empty) state_q <= S_HDR;
                end
                S_HDR: begin
                    if (rd_en_d) begin
                        hbuf_q[idx_q] <= i_fifo_tdata;
                        idx_q         <= idx_q + 4'd1;
                        if (runt) begin
                            drop_cnt_q <= sat_inc(drop_cnt_q);
                            state_q    <= S_IDLE;
                        end else if (hdr_done) begin
                            hdr_last_q <= i_fifo_tlast;
                            if (is_ipv4) begin
                                state_q   <= S_LOOKUP;
                                timer_q   <= '0;
                                lkp_req_q <= 1'b1;
                                src_ip_q  <= {hbuf_q[6][15:0], hbuf_q[7][31:16]};
                                dst_ip_q  <= {hbuf_q[7][15:0], i_fifo_tdata[31:16]};
                                proto_q   <= hbuf_q[5][7:0];
                            end
                        end
                    end
                end
                S_LOOKUP: begin
                    timer_q <= timer_q + 1'b1;
                    if (lkp_ack || lkp_timeout) lkp_req_q <= 1'b0;
                    if (lkp_timeout) timeout_cnt_q <= sat_inc(timeout_cnt_q);
                end
                S_FWD_HDR: begin
                    if (i_txd_tready) begin
                        if (idx_q == LAST_IDX) begin
                            if (hdr_last_q) begin
                                fwd_cnt_q <= sat_inc(fwd_cnt_q);
                                state_q   <= S_IDLE;
                            end else begin
                                state_q <= S_FWD_BODY;
                            end
                        end else begin
                            idx_q <= idx_q + 4'd1;
                        end
                    end
                end
                S_FWD_BODY: begin
                    if (rd_en_d && i_fifo_tlast) begin
                        fwd_cnt_q <= sat_inc(fwd_cnt_q);
                        state_q   <= S_IDLE;
                    end
                end
                S_DROP: begin
                    if (rd_en_d && i_fifo_tlast) begin
                        drop_cnt_q <= sat_inc(drop_cnt_q);
                        state_q    <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase

            // A header-only frame (tlast on the last header word) has nothing left to discard.
            if (decide) begin
                if (permit) begin
                    state_q <= S_FWD_HDR;
                    idx_q   <= '0;
                end else if (!frame_last) begin
                    state_q <= S_DROP;
                end else begin
                    drop_cnt_q <= sat_inc(drop_cnt_q);
                    state_q    <= S_IDLE;
                end
            end
        end
    end

    assign o_fifo_rd_en  = rd_en_d;
    assign o_txd_tvalid  = tvalid_d;
    assign o_txd_tdata   = tdata_d;
    assign o_txd_tlast   = tlast_d;
    assign o_lkp_req     = lkp_req_q;
    assign o_lkp_src_ip  = src_ip_q;
    assign o_lkp_dst_ip  = dst_ip_q;
    assign o_lkp_proto   = proto_q;
    assign o_fwd_cnt     = fwd_cnt_q;
    assign o_drop_cnt    = drop_cnt_q;
    assign o_timeout_cnt = timeout_cnt_q;

endmodule

// File: tb/tb_acl_frame_fwd_ctrl.sv
// Scoreboard bench for acl_frame_fwd_ctrl: a FIFO model feeds frames, an ACL responder answers
// lookups, and a monitor compares every accepted egress word against the expected queue.
module tb_acl_frame_fwd_ctrl;

    localparam int CNT_W = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic             fifoEmpty;
    logic [31:0]      fifoTdata;
    logic             fifoTlast;
    logic             fifoRdEn;
    logic             lkpReq;
    logic [31:0]      lkpSrcIp;
    logic [31:0]      lkpDstIp;
    logic [7:0]       lkpProto;
    logic             lkpAck;
    logic             lkpPermit;
    logic [31:0]      txdTdata;
    logic             txdTvalid;
    logic             txdTlast;
    logic             txdTready;
    logic [CNT_W-1:0] fwdCnt;
    logic [CNT_W-1:0] dropCnt;
    logic [CNT_W-1:0] timeoutCnt;

    acl_frame_fwd_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .i_fifo_empty (fifoEmpty),
        .i_fifo_tdata (fifoTdata),
        .i_fifo_tlast (fifoTlast),
        .o_fifo_rd_en (fifoRdEn),
        .o_lkp_req    (lkpReq),
        .o_lkp_src_ip (lkpSrcIp),
        .o_lkp_dst_ip (lkpDstIp),
        .o_lkp_proto  (lkpProto),
        .i_lkp_ack    (lkpAck),
        .i_lkp_permit (lkpPermit),
        .o_txd_tdata  (txdTdata),
        .o_txd_tvalid (txdTvalid),
        .o_txd_tlast  (txdTlast),
        .i_txd_tready (txdTready),
        .o_fwd_cnt    (fwdCnt),
        .o_drop_cnt   (dropCnt),
        .o_timeout_cnt(timeoutCnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Ingress FIFO model, flushed by the shared reset.
    logic [32:0] fifoMem [0:1023];
    int          wrPtr = 0;
    int          rdPtr = 0;
    int          lastRd = 0;
    logic        gap;
    bit          randMode = 0;

    assign fifoEmpty = (rdPtr == wrPtr) || gap;
    assign fifoTdata = fifoMem[rdPtr[9:0]][31:0];
    assign fifoTlast = fifoMem[rdPtr[9:0]][32];

    always @(posedge clk) begin
        if (rst) rdPtr <= wrPtr;
        else if (fifoRdEn && !fifoEmpty) rdPtr <= rdPtr + 1;
    end

    // Random backpressure and arrival gaps; a gap may only open right after a pop.
    initial begin
        txdTready = 1'b1;
        gap       = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (randMode) begin
                txdTready = 1'($urandom_range(0, 1));
                if (gap) gap = ($urandom_range(0, 2) == 0);
                else if (rdPtr != lastRd) gap = ($urandom_range(0, 2) == 0);
            end else begin
                txdTready = 1'b1;
                gap       = 1'b0;
            end
            lastRd = rdPtr;
        end
    end

    // ACL responder: acks on the ackAt-th cycle of a request.
    bit          ackEn = 1;
    int          ackAt = 3;
    bit          ackPermit = 1;
    int          reqCnt = 0;
    int          reqSeen = 0;
    int          lastReqLen = 0;
    logic [71:0] capFields = '0;

    initial begin
        lkpAck    = 1'b0;
        lkpPermit = 1'b0;
        forever begin
            @(negedge clk);
            if (lkpReq) begin
                reqCnt++;
                if (reqCnt == 1) begin
                    reqSeen++;
                    capFields = {lkpSrcIp, lkpDstIp, lkpProto};
                end else begin
                    checkOutput("lkp_stable", 64'({lkpSrcIp, lkpDstIp} ^ capFields[71:8]) |
                                64'(lkpProto ^ capFields[7:0]), 64'd0);
                end
                lkpAck    = ackEn && (reqCnt == ackAt);
                lkpPermit = ackPermit;
            end else begin
                if (reqCnt != 0) lastReqLen = reqCnt;
                reqCnt = 0;
                lkpAck = 1'b0;
            end
        end
    end

    // Egress monitor and scoreboard.
    logic [32:0] expQ [$];
    int          egressCnt = 0;
    bit          holdPending = 0;
    logic [32:0] holdWord;

    initial begin
        forever begin
            @(negedge clk);
            if (fifoEmpty) checkOutput("rd_while_empty", 64'(fifoRdEn), 64'd0);
            if (holdPending) begin
                checkOutput("hold_valid", 64'(txdTvalid), 64'd1);
                checkOutput("hold_data", 64'({txdTlast, txdTdata}), 64'(holdWord));
            end
            if (txdTvalid) begin
                if (expQ.size() == 0) begin
                    checkOutput("unexpected_tvalid", 64'(txdTvalid), 64'd0);
                end else if (txdTready) begin
                    checkOutput("egress_word", 64'({txdTlast, txdTdata}), 64'(expQ.pop_front()));
                    egressCnt++;
                end
            end
            holdPending = txdTvalid && !txdTready;
            holdWord    = {txdTlast, txdTdata};
        end
    end

    int expFwd = 0;
    int expDrop = 0;
    int expTo = 0;

    task automatic applyStimulus(input int nWords, input logic [15:0] etype, input int seed, input bit fwd);
        logic [31:0] w;
        for (int i = 0; i < nWords; i++) begin
            w = 32'(seed << 16) | 32'(i);
            case (i)
                3: w = {etype, 16'hAAAA};
                5: w = 32'hCCCC_9906;
                6: w = 32'hDDDD_DDDD;
                7: w = 32'hFFFF_AAAA;
                8: w = 32'hBBBB_CCCC;
                default: ;
            endcase
            fifoMem[wrPtr[9:0]] = {(i == nWords - 1), w};
            wrPtr++;
            if (fwd) expQ.push_back({(i == nWords - 1), w});
        end
    endtask

    task automatic waitIdle(input string tag);
        bit done = 0;
        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            if (rdPtr == wrPtr && expQ.size() == 0 && !lkpReq && reqCnt == 0) begin
                done = 1;
                break;
            end
        end
        checkOutput({tag, "_complete"}, 64'(done), 64'd1);
        repeat (3) @(negedge clk);
    endtask

    task automatic checkCounters(input string tag);
        checkOutput({tag, "_fwd"}, 64'(fwdCnt), 64'(expFwd));
        checkOutput({tag, "_drop"}, 64'(dropCnt), 64'(expDrop));
        checkOutput({tag, "_timeout"}, 64'(timeoutCnt), 64'(expTo));
    endtask

    initial begin
        int seenBefore;
        int target;
        bit reached;

        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_rd_en", 64'(fifoRdEn), 64'd0);
        checkOutput("rst_req", 64'(lkpReq), 64'd0);
        checkOutput("rst_fields", 64'({lkpSrcIp, lkpDstIp} | 64'(lkpProto)), 64'd0);
        checkOutput("rst_txd", 64'({txdTvalid, txdTlast, txdTdata}), 64'd0);
        checkCounters("rst");
        @(posedge clk);
        #1 rst = 1'b0;

        // T1: permitted IPv4 frame.
        ackEn = 1; ackAt = 3; ackPermit = 1;
        applyStimulus(20, 16'h0800, 1, 1);
        waitIdle("t1");
        checkOutput("t1_src", 64'(capFields[71:40]), 64'h0000_0000_DDDD_FFFF);
        checkOutput("t1_dst", 64'(capFields[39:8]), 64'h0000_0000_AAAA_BBBB);
        checkOutput("t1_proto", 64'(capFields[7:0]), 64'h06);
        checkOutput("t1_req_len", 64'(lastReqLen), 64'd3);
        checkOutput("t1_egress_cnt", 64'(egressCnt), 64'd20);
        expFwd++;
        checkCounters("t1");

        // T2: denied frame, then a normal one.
        ackPermit = 0;
        applyStimulus(20, 16'h0800, 2, 0);
        waitIdle("t2");
        expDrop++;
        checkCounters("t2");
        ackPermit = 1;
        applyStimulus(20, 16'h0800, 3, 1);
        waitIdle("t2_next");
        expFwd++;
        checkCounters("t2_next");

        // T3: timeout, then ack on the final lookup cycle.
        ackEn = 0;
        applyStimulus(20, 16'h0800, 4, 0);
        waitIdle("t3");
        checkOutput("t3_req_len", 64'(lastReqLen), 64'd64);
        expTo++; expDrop++;
        checkCounters("t3");
        ackEn = 1; ackAt = 64; ackPermit = 1;
        applyStimulus(20, 16'h0800, 5, 1);
        waitIdle("t3_late_ack");
        checkOutput("t3_late_req_len", 64'(lastReqLen), 64'd64);
        expFwd++;
        checkCounters("t3_late_ack");

        // T4: runt, non-IPv4 default drop, header-only frame.
        ackAt = 2;
        seenBefore = reqSeen;
        applyStimulus(5, 16'h0800, 6, 0);
        waitIdle("t4_runt");
        expDrop++;
        applyStimulus(12, 16'h86DD, 7, 0);
        waitIdle("t4_nonip");
        expDrop++;
        checkOutput("t4_no_req", 64'(reqSeen), 64'(seenBefore));
        checkCounters("t4_drops");
        applyStimulus(9, 16'h0800, 8, 1);
        waitIdle("t4_hdr_only");
        expFwd++;
        checkCounters("t4_hdr_only");

        // T5: random backpressure and FIFO gaps.
        randMode = 1;
        applyStimulus(30, 16'h0800, 9, 1);
        waitIdle("t5");
        randMode = 0;
        expFwd++;
        checkCounters("t5");

        // T6: reset mid-body.
        ackAt = 1;
        target = egressCnt + 12;
        applyStimulus(20, 16'h0800, 10, 1);
        reached = 0;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            if (egressCnt >= target) begin
                reached = 1;
                break;
            end
        end
        checkOutput("t6_reach_body", 64'(reached), 64'd1);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        expQ.delete();
        @(negedge clk);
        checkOutput("t6_txd", 64'({txdTvalid, txdTlast, txdTdata}), 64'd0);
        checkOutput("t6_rd_en", 64'(fifoRdEn), 64'd0);
        checkOutput("t6_req", 64'(lkpReq), 64'd0);
        expFwd = 0; expDrop = 0; expTo = 0;
        checkCounters("t6_rst");
        applyStimulus(12, 16'h0800, 11, 1);
        waitIdle("t6_next");
        expFwd++;
        checkCounters("t6_next");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
